booth_mult_arbiter: RTL and testbench
=====================================

// Module: booth_mult_arbiter
// PURPOSE
//   Shares one iterative radix-2 Booth multiplier among NREQ requesters.
//   - Round-robin arbitration, valid/ready handshake on each request port.
//   - One Booth step per clock.
//   - Result in the team's sign-magnitude form: magnitude prod plus sign flag.
//   - Sits between the operand sources and any consumer of signed products.
// PARAMETERS
//   NREQ   4  number of requesters (>=2)
//   WIDTH  4  operand width in bits, two's complement; product is 2*WIDTH bits
// PORTS
//   clk               in   1              clock, all logic on posedge
//   rst               in   1              synchronous active-high reset
//   req_valid         in   NREQ           request i valid
//   req_ready         out  NREQ           request i accepted this cycle (one-hot or 0)
//   req_multiplier    in   NREQ*WIDTH     slice i = multiplier of requester i
//   req_multiplicand  in   NREQ*WIDTH     slice i = multiplicand of requester i
//   rsp_valid         out  1              result valid
//   rsp_ready         in   1              consumer takes result
//   rsp_id            out  clog2(NREQ)    index of requester owning the result
//   rsp_prod          out  2*WIDTH        magnitude of product
//   rsp_sign          out  1              1 = product negative
//   busy              out  1              high in ITER and DONE
// BEHAVIOUR
//   - Reset (rst=1 at posedge):
//     - state=IDLE, rr_ptr=0.
//     - rsp_valid=0, rsp_id=0, rsp_prod=0, rsp_sign=0, busy=0.
//     - req_ready=0 while rst is high.
//     - An in-flight operation is dropped; no response is ever issued for it.
//   - FSM states: IDLE, ITER, DONE.
//   - IDLE:
//     - g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
//     - req_ready[g]=1 combinationally; all other req_ready bits are 0.
//     - Handshake at that posedge: latch operands and rsp_id=g.
//     - Set A=0 (WIDTH+1 bits), Q=multiplier, Q_1=0, M=multiplicand sign-extended to WIDTH+1, cnt=0.
//     - Go to ITER.
//     - No req_valid: stay in IDLE.
//   - ITER, once per cycle:
//     - {Q[0],Q_1}=01: A+=M.
//     - {Q[0],Q_1}=10: A-=M.
//     - 00 or 11: A unchanged.
//     - Then arithmetic right shift of {A,Q,Q_1}; cnt++.
//     - After WIDTH steps go to DONE.
//     - A is WIDTH+1 bits so that M = -2^(WIDTH-1) does not overflow.
//   - DONE:
//     - P = {A[WIDTH-1:0],Q} as 2*WIDTH two's complement.
//     - Registered on entry: P[MSB]=1 gives rsp_prod=-P, rsp_sign=1; otherwise rsp_prod=P, rsp_sign=0.
//     - rsp_valid=1.
//     - rsp_valid, rsp_id, rsp_prod and rsp_sign hold stable until rsp_ready.
//     - rsp_valid & rsp_ready: go to IDLE, rr_ptr=(rsp_id+1) mod NREQ, rsp_valid=0.
//     - rsp_prod, rsp_sign and rsp_id keep their last values after the handshake.
//   - Latency: request accepted at edge T, rsp_valid high from edge T+WIDTH+1.
//     - The next grant is no earlier than the cycle after the response handshake.
//   - Throughput: at most one product per WIDTH+2 cycles.
//   - No request is accepted outside IDLE; req_ready stays 0 in ITER and DONE.
//   - A requester may drop req_valid before it is granted; nothing is latched for it.
//   - Operand changes after acceptance have no effect.
//   - Range: the magnitude always fits 2*WIDTH bits; the worst case is (-2^(W-1))^2 = 2^(2W-2).
//   - Zero product always gives rsp_sign=0.
// TESTING
//   - Only req0 valid, 3*2: req_ready[0] for 1 cycle; 5 cycles later rsp_valid=1, prod=6, sign=0, id=0.
//   - req1 = -3*5 -> prod=15, sign=1, id=1; req2 = 0*-7 -> prod=0, sign=0.
//   - Boundary operands: -8*-8 -> 64, sign 0; -8*7 -> 56, sign 1; 7*7 -> 49, sign 0; -1*-1 -> 1, sign 0.
//   - All four req_valid held high, rsp_ready=1: grant order 0,1,2,3,0,... and each response id matches its grant.
//   - Response backpressure: rsp_ready=0 for 3 cycles in DONE -> outputs stable and req_ready all 0; grant follows the handshake.
//   - rst pulsed in ITER with req2 in flight -> no rsp_valid; next request from req0 and req2 together -> grant 0 (rr_ptr=0).

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin shared radix-2 Booth multiplier with sign-magnitude result
module booth_mult_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_multiplier,
  input  logic [NREQ*WIDTH-1:0]   req_multiplicand,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [2*WIDTH-1:0]      rsp_prod,
  output logic                    rsp_sign,
  output logic                    busy
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(WIDTH+1);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] rr_ptr, gnt;
  logic found, accept, q1;
  logic [WIDTH-1:0] mpr, mcd, q;
  logic [WIDTH:0] a, m, sum;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] p;
  assign sum = ({q[0], q1} == 2'b01) ? a + m : ({q[0], q1} == 2'b10) ? a - m : a;
  assign p = {a[WIDTH-1:0], q};
  assign rsp_valid = state == DONE;
  assign busy = state != IDLE;
  // round-robin pick: lowest valid index at or above rr_ptr, else lowest valid index overall
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int i = NREQ-1; i >= 0; i--)
      if (req_valid[i]) begin
        gnt = IW'(i);
        found = 1'b1;
      end
    for (int i = NREQ-1; i >= 0; i--)
      if (req_valid[i] && IW'(i) >= rr_ptr) gnt = IW'(i);
    mpr = '0;
    mcd = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt == IW'(i)) begin
        mpr = req_multiplier[i*WIDTH +: WIDTH];
        mcd = req_multiplicand[i*WIDTH +: WIDTH];
      end
  end
  // next state and grant; ITER runs WIDTH steps plus one cycle that registers the result
  always_comb begin
    state_n = state;
    req_ready = '0;
    accept = 1'b0;
    if (state == IDLE && found && !rst) begin
      accept = 1'b1;
      req_ready = NREQ'(1) << gnt;
      state_n = ITER;
    end
    if (state == ITER && cnt == CW'(WIDTH)) state_n = DONE;
    if (state == DONE && rsp_ready) state_n = IDLE;
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // Booth datapath, result registers and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      q <= '0;
      q1 <= 1'b0;
      m <= '0;
      cnt <= '0;
      rr_ptr <= '0;
      rsp_id <= '0;
      rsp_prod <= '0;
      rsp_sign <= 1'b0;
    end else begin
      if (accept) begin
        a <= '0;
        q <= mpr;
        q1 <= 1'b0;
        m <= {mcd[WIDTH-1], mcd};
        cnt <= '0;
        rsp_id <= gnt;
      end else if (state == ITER && cnt != CW'(WIDTH)) begin
        a <= {sum[WIDTH], sum[WIDTH:1]};
        q <= {sum[0], q[WIDTH-1:1]};
        q1 <= q[0];
        cnt <= cnt + 1'b1;
      end else if (state == ITER) begin
        rsp_prod <= p[2*WIDTH-1] ? -p : p;
        rsp_sign <= p[2*WIDTH-1];
      end
      if (rsp_valid && rsp_ready) rr_ptr <= (rsp_id == IW'(NREQ-1)) ? '0 : rsp_id + 1'b1;
    end
  end
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter: scoreboard bench for the shared Booth multiplier
module tb_booth_mult_arbiter;
  localparam int NREQ = 4;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*W-1:0] req_multiplier, req_multiplicand;
  logic rsp_valid, rsp_ready, rsp_sign, busy;
  logic [1:0] rsp_id;
  logic [2*W-1:0] rsp_prod;
  int checks = 0;
  int errors = 0;
  int n;
  logic [10:0] sb[$];
  logic [10:0] e, held;
  int gq[$];
  always #5 clk = ~clk;
  booth_mult_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_multiplier(req_multiplier), .req_multiplicand(req_multiplicand),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_prod(rsp_prod), .rsp_sign(rsp_sign), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [10:0] model(input int id, input logic [W-1:0] x, input logic [W-1:0] y);
    int xi = int'($signed(x));
    int yi = int'($signed(y));
    int pr = xi * yi;
    int mag = pr < 0 ? -pr : pr;
    return {2'(id), pr < 0, 8'(mag)};
  endfunction
  // scoreboard: push expected result on each grant, pop and compare on each response handshake
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e[10:9]);
        chk("rsp_sign", rsp_sign, e[8]);
        chk("rsp_prod", rsp_prod, e[7:0]);
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i]) begin
        gq.push_back(i);
        sb.push_back(model(i, req_multiplier[i*W +: W], req_multiplicand[i*W +: W]));
      end
    chk("ready_onehot", $onehot0(req_ready), 1);
    if (busy || rst) chk("ready_blocked", req_ready, 0);
  end
  task automatic send(input int r, input logic [W-1:0] x, input logic [W-1:0] y);
    int k = 0;
    req_multiplier[r*W +: W] = x;
    req_multiplicand[r*W +: W] = y;
    req_valid[r] = 1'b1;
    @(negedge clk);
    while (!req_ready[r] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("grant_wait", req_ready[r], 1);
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
  endtask
  task automatic drain();
    int k = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain_busy", busy, 0);
    chk("drain_sb", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_multiplier = '0;
    req_multiplicand = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 req_valid = '1;
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_prod", rsp_prod, 0);
    chk("rst_sign", rsp_sign, 0);
    @(posedge clk);
    #1 req_valid = '0;
    rst = 1'b0;
    send(0, 4'd3, 4'd2);
    for (int i = 0; i < 5; i++) begin
      chk("lat_wait", rsp_valid, 0);
      @(posedge clk);
      #1;
    end
    chk("lat_valid", rsp_valid, 1);
    chk("lat_prod", rsp_prod, 6);
    drain();
    send(1, 4'hD, 4'd5);
    drain();
    send(2, 4'd0, 4'h9);
    drain();
    send(0, 4'h8, 4'h8);
    drain();
    send(1, 4'h8, 4'd7);
    drain();
    send(2, 4'd7, 4'd7);
    drain();
    send(3, 4'hF, 4'hF);
    drain();
    gq.delete();
    for (int i = 0; i < NREQ; i++) begin
      req_multiplier[i*W +: W] = 4'(i + 2);
      req_multiplicand[i*W +: W] = 4'(13 - 3*i);
    end
    req_valid = '1;
    n = 0;
    while (gq.size() < 8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = '0;
    chk("rr_count", gq.size(), 8);
    for (int i = 0; i < 8; i++) chk("rr_order", i < gq.size() ? gq[i] : -1, i % 4);
    drain();
    rsp_ready = 1'b0;
    send(0, 4'd5, 4'hA);
    req_multiplier[1*W +: W] = 4'd3;
    req_multiplicand[1*W +: W] = 4'hC;
    req_valid[1] = 1'b1;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", rsp_valid, 1);
    held = {rsp_id, rsp_sign, rsp_prod};
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid, rsp_id, rsp_sign, rsp_prod}, {1'b1, held});
      chk("bp_ready", req_ready, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 chk("bp_grant", req_ready, 4'b0010);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    drain();
    send(2, 4'd3, 4'd3);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    chk("rst_idle", busy, 0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("rst_drop", n, 0);
    @(posedge clk);
    #1 req_multiplier[0 +: W] = 4'd2;
    req_multiplicand[0 +: W] = 4'hB;
    req_multiplier[2*W +: W] = 4'd6;
    req_multiplicand[2*W +: W] = 4'd2;
    req_valid = 4'b0101;
    @(negedge clk);
    chk("rst_ptr", req_ready, 4'b0001);
    @(posedge clk);
    #1 req_valid = '0;
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
